// File: rtl/alu_operand_stage.sv
// ID/EX issue stage: resolves SrcA/SrcB (optionally with RAW forwarding) and registers them
// for the ALU behind a valid/ready handshake with a 2-entry skid buffer.
// Optional feature: define ALU_OPERAND_FWD_EN to add EX/MEM and MEM/WB forwarding ports.
module alu_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    RD1,
  input  logic [DATA_WIDTH-1:0]    RD2,
  input  logic [DATA_WIDTH-1:0]    ImmG,
  input  logic                     ALUSrc,
  input  logic [OPCODE_LENGTH-1:0] Op_in,
  input  logic [REG_ADDR-1:0]      rs1,
  input  logic [REG_ADDR-1:0]      rs2,
  input  logic [REG_ADDR-1:0]      rd,
  input  logic                     RegWrite_in,
  input  logic                     flush,
`ifdef ALU_OPERAND_FWD_EN
  input  logic                     exmem_RegWrite,
  input  logic [REG_ADDR-1:0]      exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_ALUResult,
  input  logic                     memwb_RegWrite,
  input  logic [REG_ADDR-1:0]      memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_WrData,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [REG_ADDR-1:0]      rd_out,
  output logic                     RegWrite_out
);

  logic [DATA_WIDTH-1:0]    op1;
  logic [DATA_WIDTH-1:0]    op2;
  logic [DATA_WIDTH-1:0]    in_srca;
  logic [DATA_WIDTH-1:0]    in_srcb;

  logic                     main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0]    main_srca_q, main_srca_d;
  logic [DATA_WIDTH-1:0]    main_srcb_q, main_srcb_d;
  logic [OPCODE_LENGTH-1:0] main_op_q, main_op_d;
  logic [REG_ADDR-1:0]      main_rd_q, main_rd_d;
  logic                     main_rw_q, main_rw_d;

  logic                     skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0]    skid_srca_q, skid_srca_d;
  logic [DATA_WIDTH-1:0]    skid_srcb_q, skid_srcb_d;
  logic [OPCODE_LENGTH-1:0] skid_op_q, skid_op_d;
  logic [REG_ADDR-1:0]      skid_rd_q, skid_rd_d;
  logic                     skid_rw_q, skid_rw_d;

  logic                     in_ready_q, in_ready_d;
  logic                     accept;
  logic                     issue;

  // Per-operand resolution: index 0 is rs1/RD1, index 1 is rs2/RD2.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [DATA_WIDTH-1:0] rf_val;
      logic [DATA_WIDTH-1:0] val;
      assign rf_val = (gi == 0) ? RD1 : RD2;
`ifdef ALU_OPERAND_FWD_EN
      logic [REG_ADDR-1:0] rs_idx;
      assign rs_idx = (gi == 0) ? rs1 : rs2;
      // EX/MEM is the younger producer, so it wins over MEM/WB; x0 always reads the file.
      always_comb begin
        val = rf_val;
        if (rs_idx != '0) begin
          if (exmem_RegWrite && (exmem_rd == rs_idx)) begin
            val = exmem_ALUResult;
          end else if (memwb_RegWrite && (memwb_rd == rs_idx)) begin
            val = memwb_WrData;
          end
        end
      end
`else
      assign val = rf_val;
`endif
    end
  endgenerate

`ifndef ALU_OPERAND_FWD_EN
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
`endif

  assign op1     = g_opnd[0].val;
  assign op2     = g_opnd[1].val;
  assign in_srca = op1;
  assign in_srcb = ALUSrc ? ImmG : op2;

  assign accept = in_valid & in_ready_q;
  assign issue  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_srca_d  = main_srca_q;
    main_srcb_d  = main_srcb_q;
    main_op_d    = main_op_q;
    main_rd_d    = main_rd_q;
    main_rw_d    = main_rw_q;
    skid_valid_d = skid_valid_q;
    skid_srca_d  = skid_srca_q;
    skid_srcb_d  = skid_srcb_q;
    skid_op_d    = skid_op_q;
    skid_rd_d    = skid_rd_q;
    skid_rw_d    = skid_rw_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (issue) begin
      // accept cannot coincide with a full skid because in_ready_q is low then
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_srca_d  = skid_srca_q;
        main_srcb_d  = skid_srcb_q;
        main_op_d    = skid_op_q;
        main_rd_d    = skid_rd_q;
        main_rw_d    = skid_rw_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_srca_d  = in_srca;
        main_srcb_d  = in_srcb;
        main_op_d    = Op_in;
        main_rd_d    = rd;
        main_rw_d    = RegWrite_in;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_srca_d  = in_srca;
        main_srcb_d  = in_srcb;
        main_op_d    = Op_in;
        main_rd_d    = rd;
        main_rw_d    = RegWrite_in;
      end else begin
        skid_valid_d = 1'b1;
        skid_srca_d  = in_srca;
        skid_srcb_d  = in_srcb;
        skid_op_d    = Op_in;
        skid_rd_d    = rd;
        skid_rw_d    = RegWrite_in;
      end
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_srca_q  <= '0;
      main_srcb_q  <= '0;
      main_op_q    <= '0;
      main_rd_q    <= '0;
      main_rw_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_srca_q  <= '0;
      skid_srcb_q  <= '0;
      skid_op_q    <= '0;
      skid_rd_q    <= '0;
      skid_rw_q    <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_srca_q  <= main_srca_d;
      main_srcb_q  <= main_srcb_d;
      main_op_q    <= main_op_d;
      main_rd_q    <= main_rd_d;
      main_rw_q    <= main_rw_d;
      skid_valid_q <= skid_valid_d;
      skid_srca_q  <= skid_srca_d;
      skid_srcb_q  <= skid_srcb_d;
      skid_op_q    <= skid_op_d;
      skid_rd_q    <= skid_rd_d;
      skid_rw_q    <= skid_rw_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_valid_q;
  assign SrcA         = main_srca_q;
  assign SrcB         = main_srcb_q;
  assign Operation    = main_op_q;
  assign rd_out       = main_rd_q;
  assign RegWrite_out = main_rw_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised bench for alu_operand_stage: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours ALU_OPERAND_FWD_EN when defined.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] RD1 = '0, RD2 = '0, ImmG = '0;
  logic        ALUSrc = 1'b0;
  logic [3:0]  Op_in = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        RegWrite_in = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic [4:0]  rd_out;
  logic        RegWrite_out;
`ifdef ALU_OPERAND_FWD_EN
  logic        exmem_RegWrite = 1'b0, memwb_RegWrite = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_ALUResult = '0, memwb_WrData = '0;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .RD1(RD1), .RD2(RD2), .ImmG(ImmG), .ALUSrc(ALUSrc), .Op_in(Op_in),
    .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite_in(RegWrite_in), .flush(flush),
`ifdef ALU_OPERAND_FWD_EN
    .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_ALUResult(exmem_ALUResult),
    .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_WrData(memwb_WrData),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .rd_out(rd_out), .RegWrite_out(RegWrite_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
  } ent_t;

  ent_t q[$];
  ent_t m_last = '0;
  bit   m_in_ready = 1'b0;

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
`ifdef ALU_OPERAND_FWD_EN
    if (idx == 5'd0) return rf;
    if (exmem_RegWrite && exmem_rd == idx) return exmem_ALUResult;
    if (memwb_RegWrite && memwb_rd == idx) return memwb_WrData;
    return rf;
`else
    if (idx == 5'd31) return rf;
    return rf;
`endif
  endfunction

  always @(posedge clk) begin
    bit   acc, iss;
    ent_t e;
    acc = in_valid && m_in_ready;
    iss = (q.size() > 0) && out_ready;
    e.a  = operand(rs1, RD1);
    e.b  = ALUSrc ? ImmG : operand(rs2, RD2);
    e.op = Op_in;
    e.rd = rd;
    e.rw = RegWrite_in;
    if (!reset) begin
      q.delete();
      m_last     = '0;
      m_in_ready = 1'b0;
    end else if (flush) begin
      q.delete();
      m_in_ready = 1'b1;
    end else begin
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (q.size() > 0) m_last = q[0];
      m_in_ready = (q.size() < 2);
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
    check("SrcA", SrcA, m_last.a);
    check("SrcB", SrcB, m_last.b);
    check("Operation", {28'd0, Operation}, {28'd0, m_last.op});
    check("rd_out", {27'd0, rd_out}, {27'd0, m_last.rd});
    check("RegWrite_out", {31'd0, RegWrite_out}, {31'd0, m_last.rw});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // 1: reset
    step(); step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_SrcA", SrcA, 32'd0);
    check("rst_SrcB", SrcB, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    step();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    $display("txn reset released");

    // 2: basic transfer
    in_valid = 1'b1; RD1 = 32'd5; RD2 = 32'd7; ALUSrc = 1'b0; Op_in = 4'b0010; out_ready = 1'b1;
    step();
    check("t2_SrcA", SrcA, 32'd5);
    check("t2_SrcB", SrcB, 32'd7);
    check("t2_Op", {28'd0, Operation}, 32'd2);
    check("t2_out_valid", {31'd0, out_valid}, 32'd1);
    $display("txn basic SrcA=%0d SrcB=%0d", SrcA, SrcB);
    in_valid = 1'b0;
    step();

    // 3: back-pressure, skid fill, FIFO release
    out_ready = 1'b0; in_valid = 1'b1; RD2 = 32'd0; RD1 = 32'd11;
    step();
    RD1 = 32'd12;
    step();
    check("t3_skid_full_in_ready", {31'd0, in_ready}, 32'd0);
    RD1 = 32'd13;
    step();
    check("t3_in_ready", {31'd0, in_ready}, 32'd0);
    check("t3_head", SrcA, 32'd11);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("t3_second", SrcA, 32'd12);
    check("t3_second_valid", {31'd0, out_valid}, 32'd1);
    check("t3_in_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    check("t3_drained", {31'd0, out_valid}, 32'd0);
    check("t3_hold", SrcA, 32'd12);
    $display("txn skid release order checked");

    // 4: immediate select
    in_valid = 1'b1; ALUSrc = 1'b1; ImmG = 32'hFFFF_FFFC; RD2 = 32'd9;
    step();
    check("t4_SrcB_imm", SrcB, 32'hFFFF_FFFC);
    $display("txn imm SrcB=%h", SrcB);
    in_valid = 1'b0; ALUSrc = 1'b0;
    step();

    // 5: flush with both entries held and a third offered
    out_ready = 1'b0; in_valid = 1'b1; RD1 = 32'd21;
    step();
    RD1 = 32'd22;
    step();
    RD1 = 32'd23; flush = 1'b1;
    step();
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_data_kept", SrcA, 32'd21);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("t5_nothing_issues", {31'd0, out_valid}, 32'd0);
    $display("txn flush checked");

`ifdef ALU_OPERAND_FWD_EN
    // 6: forwarding priority and x0
    in_valid = 1'b1; rs1 = 5'd3; RD1 = 32'd99;
    exmem_RegWrite = 1'b1; exmem_rd = 5'd3; exmem_ALUResult = 32'd10;
    memwb_RegWrite = 1'b1; memwb_rd = 5'd3; memwb_WrData = 32'd20;
    step();
    check("t6_exmem", SrcA, 32'd10);
    exmem_rd = 5'd4;
    step();
    check("t6_memwb", SrcA, 32'd20);
    rs1 = 5'd0; exmem_rd = 5'd0; memwb_rd = 5'd0; RD1 = 32'd55;
    step();
    check("t6_x0", SrcA, 32'd55);
    $display("txn forwarding checked");
    in_valid = 1'b0; exmem_RegWrite = 1'b0; memwb_RegWrite = 1'b0;
    step();
`endif

    // random phase
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 9) < 6);
      RD1         = $urandom;
      RD2         = $urandom;
      ImmG        = $urandom;
      ALUSrc      = $urandom_range(0, 1);
      Op_in       = 4'($urandom);
      rs1         = 5'($urandom_range(0, 3));
      rs2         = 5'($urandom_range(0, 3));
      rd          = 5'($urandom);
      RegWrite_in = $urandom_range(0, 1);
`ifdef ALU_OPERAND_FWD_EN
      exmem_RegWrite  = $urandom_range(0, 1);
      exmem_rd        = 5'($urandom_range(0, 3));
      exmem_ALUResult = $urandom;
      memwb_RegWrite  = $urandom_range(0, 1);
      memwb_rd        = 5'($urandom_range(0, 3));
      memwb_WrData    = $urandom;
`endif
      step();
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
